// File: rtl/univ_counter_sweep_ctrl_pkg.sv
// Shared definitions for the counter sweep sequencer: sweep modes and FSM state encoding.
package univ_counter_sweep_ctrl_pkg;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  // The reserved encoding behaves exactly like a one-shot sweep.
  function automatic logic [1:0] norm_mode(input logic [1:0] mode);
    return (mode == MODE_RELOAD || mode == MODE_BOUNCE) ? mode : MODE_ONESHOT;
  endfunction

endpackage

// File: rtl/univ_bin_counter.sv
// Universal binary counter: synchronous clear > load > count enable, up/down selectable.
module univ_bin_counter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         syn_clr,
  input  logic         load,
  input  logic         en,
  input  logic         up,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (syn_clr) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (en) begin
      q <= up ? (q + ONE) : (q - ONE);
    end
  end

endmodule

// File: rtl/univ_counter_sweep_ctrl.sv
// Sequencer that drives a universal binary counter through commanded sweeps
// (one-shot, reload-and-repeat or bounce) with a programmable pass count and abort.
module univ_counter_sweep_ctrl
  import univ_counter_sweep_ctrl_pkg::*;
#(
  parameter int N  = 8,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [N-1:0]  cmd_start,
  input  logic [N-1:0]  cmd_end,
  input  logic [1:0]    cmd_mode,
  input  logic [LW-1:0] cmd_loops,
  input  logic          abort,
  input  logic [N-1:0]  cnt_q,
  output logic          cnt_syn_clr,
  output logic          cnt_load,
  output logic          cnt_en,
  output logic          cnt_up,
  output logic [N-1:0]  cnt_d,
  output logic          busy,
  output logic          pass_done,
  output logic          done,
  output logic          aborted
);

  localparam logic [LW-1:0] PASS_ONE = {{(LW-1){1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [N-1:0]  start_q, start_d;
  logic [N-1:0]  end_q, end_d;
  logic [N-1:0]  target_q, target_d;
  logic [1:0]    mode_q, mode_d;
  logic [LW-1:0] loops_q, loops_d;
  logic [LW-1:0] pass_cnt_q, pass_cnt_d;
  logic          dir_q, dir_d;

  logic          at_target;
  logic          last_pass;

  assign at_target = (cnt_q == target_q);
  // A zero loop count never matches, so the sweep repeats until aborted.
  assign last_pass = (loops_q != '0) && ((pass_cnt_q + PASS_ONE) == loops_q);
  assign busy      = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      start_q    <= '0;
      end_q      <= '0;
      target_q   <= '0;
      mode_q     <= MODE_ONESHOT;
      loops_q    <= '0;
      pass_cnt_q <= '0;
      dir_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      end_q      <= end_d;
      target_q   <= target_d;
      mode_q     <= mode_d;
      loops_q    <= loops_d;
      pass_cnt_q <= pass_cnt_d;
      dir_q      <= dir_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    end_d       = end_q;
    target_d    = target_q;
    mode_d      = mode_q;
    loops_d     = loops_q;
    pass_cnt_d  = pass_cnt_q;
    dir_d       = dir_q;
    cmd_ready   = 1'b0;
    cnt_syn_clr = 1'b0;
    cnt_load    = 1'b0;
    cnt_en      = 1'b0;
    cnt_up      = 1'b0;
    cnt_d       = '0;
    pass_done   = 1'b0;
    done        = 1'b0;
    aborted     = 1'b0;

    if (state_q != ST_IDLE && abort) begin
      // Abort overrides whatever the active state would have done this cycle.
      cnt_syn_clr = 1'b1;
      aborted     = 1'b1;
      state_d     = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            start_d    = cmd_start;
            end_d      = cmd_end;
            mode_d     = norm_mode(cmd_mode);
            loops_d    = cmd_loops;
            target_d   = cmd_end;
            dir_d      = (cmd_end >= cmd_start);
            pass_cnt_d = '0;
            state_d    = ST_LOAD;
          end
        end

        ST_LOAD: begin
          cnt_load = 1'b1;
          cnt_d    = start_q;
          state_d  = ST_RUN;
        end

        ST_RUN: begin
          cnt_up = dir_q;
          if (!at_target) begin
            cnt_en = 1'b1;
          end else begin
            pass_done  = 1'b1;
            pass_cnt_d = pass_cnt_q + PASS_ONE;
            if (last_pass) begin
              state_d = ST_FINISH;
            end else if (mode_q == MODE_RELOAD) begin
              state_d = ST_LOAD;
            end else if (mode_q == MODE_BOUNCE) begin
              // Turn around: the counter dwells one cycle on the turn value.
              target_d = (target_q == end_q) ? start_q : end_q;
              dir_d    = ~dir_q;
            end else begin
              state_d = ST_FINISH;
            end
          end
        end

        ST_FINISH: begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_univ_counter_sweep_ctrl.sv
// Self-checking bench: sweep controller driving a real counter, checked against a
// pass-by-pass schedule model plus literal traces from hand-worked sweeps.
module tb_univ_counter_sweep_ctrl;

  localparam int N  = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [N-1:0]  cmd_start;
  logic [N-1:0]  cmd_end;
  logic [1:0]    cmd_mode;
  logic [LW-1:0] cmd_loops;
  logic          abort;
  logic [N-1:0]  cnt_q;
  logic          cnt_syn_clr;
  logic          cnt_load;
  logic          cnt_en;
  logic          cnt_up;
  logic [N-1:0]  cnt_d;
  logic          busy;
  logic          pass_done;
  logic          done;
  logic          aborted;

  always #5 clk = ~clk;

  univ_counter_sweep_ctrl #(.N(N), .LW(LW)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_start  (cmd_start),
    .cmd_end    (cmd_end),
    .cmd_mode   (cmd_mode),
    .cmd_loops  (cmd_loops),
    .abort      (abort),
    .cnt_q      (cnt_q),
    .cnt_syn_clr(cnt_syn_clr),
    .cnt_load   (cnt_load),
    .cnt_en     (cnt_en),
    .cnt_up     (cnt_up),
    .cnt_d      (cnt_d),
    .busy       (busy),
    .pass_done  (pass_done),
    .done       (done),
    .aborted    (aborted)
  );

  univ_bin_counter #(.N(N)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .syn_clr(cnt_syn_clr),
    .load   (cnt_load),
    .en     (cnt_en),
    .up     (cnt_up),
    .d      (cnt_d),
    .q      (cnt_q)
  );

  // One expected cycle of an accepted sweep: kind 0 = load, 1 = run, 2 = finish.
  typedef struct {
    int kind;
    int q;
    int en;
    int up;
    int d;
    int pd;
  } exp_t;

  exp_t expQ[$];
  exp_t h;
  int   total = 0;
  int   bad = 0;
  bit   active = 0;
  int   mStart, mEnd, mMode, mLoops, passIdx;
  int   modelQ = 0;
  int   passDoneCnt = 0;
  int   doneCnt = 0;
  int   abortCnt = 0;
  int   trace[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Appends the cycles of the next pass, derived from the endpoints and pass index.
  function automatic void appendPass();
    int  from, to, up, q;
    bit  last;
    if (mMode == 2 && (passIdx % 2) == 1) begin
      from = mEnd;
      to   = mStart;
    end else begin
      from = mStart;
      to   = mEnd;
    end
    if (from == to) up = (mMode == 2) ? ((passIdx % 2) == 0) : 1;
    else            up = (to > from) ? 1 : 0;
    if (passIdx == 0 || mMode == 1)
      expQ.push_back('{kind: 0, q: -1, en: 0, up: 0, d: mStart, pd: 0});
    q = from;
    forever begin
      expQ.push_back('{kind: 1, q: q, en: (q != to), up: up, d: 0, pd: (q == to)});
      if (q == to) break;
      q = up ? q + 1 : q - 1;
    end
    last = (mMode != 1 && mMode != 2) || (mLoops != 0 && passIdx + 1 == mLoops);
    if (last) expQ.push_back('{kind: 2, q: -1, en: 0, up: 0, d: 0, pd: 0});
    passIdx++;
  endfunction

  function automatic logic [8:0] flags();
    return {cmd_ready, busy, cnt_syn_clr, cnt_load, cnt_en, cnt_up, pass_done, done, aborted};
  endfunction

  task automatic checkIdle();
    checkOutput("idle_flags", flags(), 9'b100000000);
    checkOutput("idle_d", cnt_d, 0);
    checkOutput("idle_q", cnt_q, modelQ);
  endtask

  // Compare process: every falling edge the outputs are judged against the model.
  always @(negedge clk) begin
    if (!reset) begin
      expQ.delete();
      active = 0;
      modelQ = 0;
      checkIdle();
    end else if (!active) begin
      checkIdle();
      if (cmd_valid) begin
        mStart  = int'(cmd_start);
        mEnd    = int'(cmd_end);
        mMode   = int'(cmd_mode);
        mLoops  = int'(cmd_loops);
        passIdx = 0;
        active  = 1;
        expQ.delete();
        appendPass();
      end
    end else begin
      if (expQ.size() == 0) appendPass();
      h = expQ[0];
      if (abort) begin
        checkOutput("abort_flags", flags(), 9'b011000001);
        checkOutput("abort_d", cnt_d, 0);
        checkOutput("abort_q", cnt_q, (h.kind == 1) ? h.q : modelQ);
        if (h.kind == 1) trace.push_back(int'(cnt_q));
        abortCnt++;
        expQ.delete();
        active = 0;
        modelQ = 0;
      end else begin
        checkOutput("run_flags", flags(),
                    {1'b0, 1'b1, 1'b0, h.kind == 0, h.en[0],
                     (h.kind == 1) ? h.up[0] : 1'b0, h.pd[0], h.kind == 2, 1'b0});
        checkOutput("run_d", cnt_d, (h.kind == 0) ? h.d : 0);
        checkOutput("run_q", cnt_q, (h.kind == 1) ? h.q : modelQ);
        if (h.kind == 1) trace.push_back(int'(cnt_q));
        passDoneCnt += h.pd;
        if (h.kind == 0) modelQ = h.d;
        else if (h.kind == 1) modelQ = h.en ? (h.up ? h.q + 1 : h.q - 1) : h.q;
        if (h.kind == 2) begin
          doneCnt++;
          active = 0;
        end
        void'(expQ.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      tick();
      n++;
    end
    if (busy) checkOutput("idle_wait", busy, 0);
  endtask

  task automatic applyStimulus(input int s, input int e, input int m, input int l);
    waitIdle(2000);
    cmd_start = N'(s);
    cmd_end   = N'(e);
    cmd_mode  = 2'(m);
    cmd_loops = LW'(l);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic checkTrace(input string name, input int base, input int want[$]);
    checkOutput({name, "_len"}, trace.size() - base, want.size());
    for (int i = 0; i < want.size(); i++)
      if (base + i < trace.size()) checkOutput({name, "_q"}, trace[base + i], want[i]);
  endtask

  task automatic runSweep(input string name, input int s, input int e, input int m,
                          input int l, input int want[$], input int wantPasses);
    int tb0, pd0, d0, a0, n;
    applyStimulus(s, e, m, l);
    tb0 = trace.size();
    pd0 = passDoneCnt;
    d0  = doneCnt;
    a0  = abortCnt;
    n   = 0;
    while (doneCnt == d0 && abortCnt == a0 && n < 2000) begin
      tick();
      n++;
    end
    checkOutput({name, "_done"}, doneCnt - d0, 1);
    checkOutput({name, "_passes"}, passDoneCnt - pd0, wantPasses);
    checkTrace(name, tb0, want);
    checkOutput({name, "_hold"}, cnt_q, e);
  endtask

  initial begin
    int tb0, d0, a0, n;
    int w[$];
    reset     = 1'b0;
    cmd_valid = 1'b0;
    abort     = 1'b0;
    cmd_start = '0;
    cmd_end   = '0;
    cmd_mode  = '0;
    cmd_loops = '0;
    repeat (2) tick();
    checkOutput("rst_ready", cmd_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_q", cnt_q, 0);
    reset = 1'b1;
    tick();

    w = '{3, 4, 5, 6};
    runSweep("oneshot_up", 3, 6, 0, 1, w, 1);
    tick();
    checkOutput("oneshot_stay", cnt_q, 6);

    // Descending sweep: cnt_up must be low on the first run cycle.
    applyStimulus(10, 7, 0, 1);
    tb0 = trace.size();
    tick();
    checkOutput("down_up", cnt_up, 0);
    checkOutput("down_first_q", cnt_q, 10);
    waitIdle(100);
    w = '{10, 9, 8, 7};
    checkTrace("oneshot_down", tb0, w);

    w = '{2, 3, 4, 2, 3, 4};
    runSweep("reload", 2, 4, 1, 2, w, 2);
    w = '{2, 3, 4, 4, 3, 2, 2, 3, 4};
    runSweep("bounce", 2, 4, 2, 3, w, 3);
    w = '{5};
    runSweep("equal_oneshot", 5, 5, 0, 1, w, 1);
    w = '{5, 5};
    runSweep("equal_bounce", 5, 5, 2, 2, w, 2);
    w = '{1, 2, 3};
    runSweep("reserved", 1, 3, 3, 4, w, 1);
    w = '{252, 253, 254, 255};
    runSweep("top_edge", 252, 255, 0, 1, w, 1);

    // Endless bounce, a foreign command mid-sweep, then abort at q=5.
    applyStimulus(0, 9, 2, 0);
    tb0 = trace.size();
    d0  = doneCnt;
    a0  = abortCnt;
    n   = 0;
    while (!(cnt_q == 5 && !cnt_load) && n < 100) begin
      cmd_valid = (cnt_q == 2);
      cmd_start = 8'd40;
      cmd_end   = 8'd50;
      tick();
      n++;
    end
    cmd_valid = 1'b0;
    checkOutput("abort_reach", cnt_q, 5);
    abort = 1'b1;
    #1;
    checkOutput("abort_clr", cnt_syn_clr, 1);
    tick();
    abort = 1'b0;
    checkOutput("abort_q0", cnt_q, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_pulse", abortCnt - a0, 1);
    checkOutput("abort_nodone", doneCnt - d0, 0);
    w = '{0, 1, 2, 3, 4, 5};
    checkTrace("abort", tb0, w);
    tick();
    checkOutput("ignored_cmd", busy, 0);

    // Asynchronous reset in the middle of a run.
    applyStimulus(0, 20, 0, 1);
    d0 = doneCnt;
    repeat (4) tick();
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_ready", cmd_ready, 1);
    checkOutput("mid_rst_ctl", {cnt_syn_clr, cnt_load, cnt_en, cnt_up, pass_done, done}, 0);
    checkOutput("mid_rst_d", cnt_d, 0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();
    checkOutput("mid_rst_nodone", doneCnt - d0, 0);

    // Randomized traffic: commands, modes, loop counts and aborts.
    for (int i = 0; i < 4000; i++) begin
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_start = N'($urandom_range(0, 24));
      cmd_end   = N'($urandom_range(0, 24));
      if ($urandom_range(0, 9) == 0) cmd_end = N'(255 - $urandom_range(0, 3));
      cmd_mode  = 2'($urandom_range(0, 3));
      cmd_loops = LW'($urandom_range(0, 4));
      abort     = ($urandom_range(0, 49) == 0);
      tick();
    end
    cmd_valid = 1'b0;
    abort     = 1'b1;
    tick();
    abort = 1'b0;
    waitIdle(100);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/univ_counter_sweep_ctrl.md
Name: univ_counter_sweep_ctrl

Overview:
- Sequencer that owns the control inputs of a universal binary counter (`syn_clr`/`load`/`en`/`up`/`d`) and watches its count value `q`.
- Runs commanded sweeps from a start value to an end value.
- Three modes: one-shot, reload-and-repeat, or bounce between the endpoints.
- Loop count is programmable; abort is supported. Sits between a host command interface and one counter instance.

Parameters:
- N, 8, counter width; must match the controlled counter.
- LW, 4, width of loop-count field.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_start  in  N  sweep start value.
- cmd_end  in  N  sweep end value.
- cmd_mode  in  2  0=ONESHOT, 1=RELOAD, 2=BOUNCE, 3=reserved (treated as ONESHOT).
- cmd_loops  in  LW  passes to execute; 0 = infinite, until abort.
- abort  in  1  terminate current sweep.
- cnt_q  in  N  counter value.
- cnt_syn_clr  out  1  to counter `syn_clr`.
- cnt_load  out  1  to counter `load`.
- cnt_en  out  1  to counter `en`.
- cnt_up  out  1  to counter `up`.
- cnt_d  out  N  to counter `d`.
- busy  out  1  high whenever state is not IDLE.
- pass_done  out  1  one-cycle pulse per completed pass.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse on abort.

Behaviour:
- Reset (`reset`=0, async):
  - state=IDLE.
  - All registers and outputs 0, except `cmd_ready`=1.
- Counter priority is `syn_clr` > `load` > `en`, with a synchronous update.
- IDLE:
  - `cmd_ready`=1; all `cnt_*` controls 0.
  - On `cmd_valid` at an edge: latch start, end, mode and loops.
  - dir = (end >= start); target = end; pass_cnt = 0; go to LOAD.
- LOAD (1 cycle):
  - `cnt_load`=1, `cnt_d`=start; next state RUN.
  - Counter holds start in the first RUN cycle.
- RUN:
  - `cnt_up`=dir.
  - If `cnt_q` != target: `cnt_en`=1.
  - If `cnt_q` == target: `cnt_en`=0, `pass_done`=1, pass_cnt++, then:
    - last pass (loops != 0 and pass_cnt+1 == loops) → FINISH;
    - else RELOAD → LOAD;
    - else BOUNCE → stay in RUN with target swapped (end↔start) and dir inverted. The counter dwells one cycle at the turn value.
- FINISH (1 cycle): `done`=1, `cnt_en`=0, then IDLE. Counter keeps its final value.
- start == end: each pass completes in its first RUN cycle. The counter never increments.
- abort:
  - Sampled in LOAD, RUN or FINISH; has priority over all transitions.
  - That cycle: `cnt_syn_clr`=1, `cnt_en`=0, `cnt_load`=0, `aborted`=1, no `done`. Next state IDLE.
  - abort in IDLE is ignored.
- `cmd_valid` while busy is ignored; the command is not latched.
- Wrap-around cannot occur, because target always lies between the endpoints.
- Latency: command accepted at edge T → `cnt_load` during cycle T+1 → first RUN cycle T+2.

Decomposition:
- Shared package holds:
  - mode localparams MODE_ONESHOT / MODE_RELOAD / MODE_BOUNCE;
  - state encoding IDLE, LOAD, RUN, FINISH.
- Single flat module; FSM plus pass counter. No sub-module.
- The bench instantiates `univ_bin_counter` alongside, wired to the `cnt_*` ports.

Test Plan:
- Reset low mid-RUN → `busy`=0, `cnt_*`=0, `cmd_ready`=1 immediately; no `done`/`pass_done`.
- ONESHOT start=3, end=6, loops=1 → q=3,4,5,6. `pass_done` at q=6; `done` the next cycle; q stays 6.
- ONESHOT start=10, end=7 → `cnt_up`=0, q=10,9,8,7. `done` after 1 pass.
- RELOAD start=2, end=4, loops=2 → q=2,3,4, LOAD, 2,3,4. Two `pass_done` pulses, then `done`.
- BOUNCE start=2, end=4, loops=3 → q=2,3,4,4,3,2,2,3,4. Three `pass_done` pulses, then `done`.
- BOUNCE loops=0, abort at q=5 of 0→9 → `cnt_syn_clr` pulse, q=0 next cycle, `aborted`=1, no `done`. A new command issued during that sweep is ignored until IDLE.
